// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed transmit path: request codes,
// PID values, CRC16 constants, line states and FSM state types.
package usb_pkg;

    // Packet request codes from the protocol controller
    typedef enum logic [1:0] {
        TX_NONE  = 2'b00,
        TX_DATA0 = 2'b01,
        TX_ACK   = 2'b10,
        TX_NAK   = 2'b11
    } tx_req_t;

    // 4-bit PID values (sent LSB first, followed by their complement)
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // CRC16: x^16 + x^15 + x^2 + 1, preset to all ones
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Line states as {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // SYNC pattern 0000_0001 in transmit order (LSB first)
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Packet FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC,
        S_EOP
    } tx_state_t;

    // Line encoder states
    typedef enum logic [1:0] {
        E_IDLE,
        E_BITS,
        E_SE0,
        E_J
    } enc_state_t;

    // PID byte on the wire: complement in the upper nibble
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

    // Bit-reverse a 16-bit word (turns the polynomial into its LSB-first form)
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// Line encoder: bit timer, bit stuffer, NRZI and EOP driver. Accepts one raw
// bit per bit time over a valid/ready handshake; a valid with bit_eop set
// closes the packet with SE0, SE0, J.
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic bit_vld,
    input  logic bit_data,
    input  logic bit_eop,
    output logic bit_rdy,
    output logic dplus,
    output logic dminus,
    output logic line_active
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    enc_state_t    state;
    logic [TW-1:0] timer;
    logic [2:0]    ones;
    logic          se0_second;
    logic [1:0]    line;
    logic          bit_end;
    logic          stuff_now;

    // NRZI: a transmitted 0 flips the line between J and K
    function automatic logic [1:0] nrzi_toggle(input logic [1:0] l);
        return (l == LINE_J) ? LINE_K : LINE_J;
    endfunction

    // A stuffed 0 takes the slot of the next raw bit, so the packet FSM waits
    assign bit_end   = (timer == '0);
    assign stuff_now = (state == E_BITS) && bit_end && (ones == 3'd6);
    assign bit_rdy   = (state == E_IDLE) ||
                       ((state == E_BITS) && bit_end && (ones != 3'd6));
    assign dplus     = line[1];
    assign dminus    = line[0];

    // Bit timing, stuffing, NRZI and EOP sequencing
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state       <= E_IDLE;
            timer       <= '0;
            ones        <= '0;
            se0_second  <= 1'b0;
            line        <= LINE_J;
            line_active <= 1'b0;
        end else begin
            case (state)
                E_IDLE, E_BITS: begin
                    if (bit_vld && bit_rdy) begin
                        timer <= RELOAD;
                        if (bit_eop) begin
                            state      <= E_SE0;
                            se0_second <= 1'b0;
                            line       <= LINE_SE0;
                            ones       <= '0;
                        end else begin
                            state       <= E_BITS;
                            line_active <= 1'b1;
                            if (bit_data) begin
                                ones <= ones + 3'd1;
                            end else begin
                                ones <= '0;
                                line <= nrzi_toggle(line);
                            end
                        end
                    end else if (stuff_now) begin
                        timer <= RELOAD;
                        ones  <= '0;
                        line  <= nrzi_toggle(line);
                    end else if (!bit_end) begin
                        timer <= timer - TW'(1);
                    end
                end
                E_SE0: begin
                    if (!bit_end) begin
                        timer <= timer - TW'(1);
                    end else if (!se0_second) begin
                        se0_second <= 1'b1;
                        timer      <= RELOAD;
                    end else begin
                        state <= E_J;
                        line  <= LINE_J;
                        timer <= RELOAD;
                    end
                end
                E_J: begin
                    if (!bit_end) begin
                        timer <= timer - TW'(1);
                    end else begin
                        state       <= E_IDLE;
                        line_active <= 1'b0;
                    end
                end
                default: state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/usb_tx.sv
// USB full-speed transmit path: packet FSM producing SYNC, PID, payload and
// CRC16 as a raw bit stream, feeding the line encoder.
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [6:0] buffer_occupancy,
    input  logic [1:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       get_tx_packet_data
);

    localparam logic [6:0]  MAX_N         = 7'(MAX_PAYLOAD);
    localparam logic [15:0] CRC_POLY_REFL = reflect16(CRC16_POLY);

    tx_state_t  state;
    tx_req_t    pkt;
    logic [3:0] bit_cnt;
    logic [6:0] bytes_left;
    logic       eop_sent;
    logic [7:0] shreg;
    logic [15:0] crc;
    logic [7:0] src_byte;
    logic       bit_vld;
    logic       bit_data;
    logic       bit_eop;
    logic       bit_rdy;
    logic       take;
    logic       line_active;

    // One LSB-first step of the serial CRC16 LFSR
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY_REFL : 16'h0000);
    endfunction

    function automatic logic [3:0] pid_of(input tx_req_t p);
        case (p)
            TX_DATA0: return PID_DATA0;
            TX_ACK:   return PID_ACK;
            default:  return PID_NAK;
        endcase
    endfunction

    // The popped byte bypasses shreg in its strobe cycle so that a one-clock
    // bit time can still start the byte on the pop edge
    always_comb begin
        src_byte = get_tx_packet_data ? tx_packet_data : shreg;
        bit_vld  = 1'b0;
        bit_data = 1'b0;
        bit_eop  = 1'b0;
        case (state)
            S_SYNC, S_PID, S_DATA: begin
                bit_vld  = 1'b1;
                bit_data = src_byte[0];
            end
            S_CRC: begin
                bit_vld  = 1'b1;
                bit_data = ~crc[0];
            end
            S_EOP: begin
                bit_vld = ~eop_sent;
                bit_eop = 1'b1;
            end
            default: ;
        endcase
    end

    assign take = bit_vld & bit_rdy;

    // Packet FSM: field sequencing, FIFO pop strobe and request rejection
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state              <= S_IDLE;
            pkt                <= TX_NONE;
            bit_cnt            <= '0;
            bytes_left         <= '0;
            eop_sent           <= 1'b0;
            tx_error           <= 1'b0;
            get_tx_packet_data <= 1'b0;
        end else begin
            get_tx_packet_data <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_packet != TX_NONE) begin
                        if (tx_packet == TX_DATA0 && buffer_occupancy > MAX_N) begin
                            tx_error <= 1'b1;
                        end else begin
                            tx_error   <= 1'b0;
                            pkt        <= tx_req_t'(tx_packet);
                            bytes_left <= (tx_packet == TX_DATA0) ? buffer_occupancy : 7'd0;
                            bit_cnt    <= '0;
                            eop_sent   <= 1'b0;
                            state      <= S_SYNC;
                        end
                    end
                end
                S_SYNC: begin
                    if (take) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            state   <= S_PID;
                        end
                    end
                end
                S_PID: begin
                    if (take) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (pkt != TX_DATA0) begin
                                state <= S_EOP;
                            end else if (bytes_left == 7'd0) begin
                                state <= S_CRC;
                            end else begin
                                state              <= S_DATA;
                                get_tx_packet_data <= 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt    <= '0;
                            bytes_left <= bytes_left - 7'd1;
                            if (bytes_left == 7'd1) begin
                                state <= S_CRC;
                            end else begin
                                get_tx_packet_data <= 1'b1;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (take) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            bit_cnt <= '0;
                            state   <= S_EOP;
                        end
                    end
                end
                S_EOP: begin
                    if (take) begin
                        eop_sent <= 1'b1;
                    end else if (eop_sent && !line_active) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: byte shifter and CRC16 LFSR, advanced on each accepted bit
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                shreg <= SYNC_BYTE;
                crc   <= CRC16_INIT;
            end
            S_SYNC: begin
                if (take) begin
                    shreg <= (bit_cnt == 4'd7) ? pid_byte(pid_of(pkt)) : {1'b0, shreg[7:1]};
                end
            end
            S_PID: begin
                if (take) begin
                    shreg <= {1'b0, shreg[7:1]};
                end
            end
            S_DATA: begin
                if (take) begin
                    shreg <= {1'b0, src_byte[7:1]};
                    crc   <= crc_step(crc, bit_data);
                end else if (get_tx_packet_data) begin
                    shreg <= tx_packet_data;
                end
            end
            S_CRC: begin
                if (take) begin
                    crc <= {1'b0, crc[15:1]};
                end
            end
            default: ;
        endcase
    end

    usb_tx_encoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_encoder (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_vld    (bit_vld),
        .bit_data   (bit_data),
        .bit_eop    (bit_eop),
        .bit_rdy    (bit_rdy),
        .dplus      (dplus_out),
        .dminus     (dminus_out),
        .line_active(line_active)
    );

    assign tx_transfer_active = line_active;

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: line levels per bit time against a packet model,
// plus hand-derived line patterns, FIFO pop counts, rejection and reset.
module tb_usb_tx;

    localparam int CPB = 8;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic [6:0] buffer_occupancy;
    logic [1:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dplus_out;
    logic       dminus_out;
    logic       get_tx_packet_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  fifo [0:7];
    logic [2:0]  rd_ptr    = 3'd0;
    int          get_count = 0;
    logic [1:0]  exp_line [$];
    logic [63:0] dp_hist;

    always #5 tb_clk = ~tb_clk;

    usb_tx #(
        .CLKS_PER_BIT(CPB),
        .MAX_PAYLOAD (64)
    ) dut (
        .clk               (tb_clk),
        .n_rst             (n_rst),
        .buffer_occupancy  (buffer_occupancy),
        .tx_packet         (tx_packet),
        .tx_packet_data    (tx_packet_data),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error),
        .dplus_out         (dplus_out),
        .dminus_out        (dminus_out),
        .get_tx_packet_data(get_tx_packet_data)
    );

    // Show-ahead FIFO model: pop on the strobe edge
    assign tx_packet_data = fifo[rd_ptr];
    always @(posedge tb_clk) begin
        if (get_tx_packet_data) begin
            rd_ptr    <= rd_ptr + 3'd1;
            get_count <= get_count + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {D+,D-} per bit time: raw bits -> stuffing -> NRZI, then EOP
    task automatic build_expected(input logic [1:0] req, input int n);
        bit          raw [$];
        logic [7:0]  b;
        logic [15:0] crc;
        logic [1:0]  lvl;
        int          ones;
        exp_line.delete();
        b = 8'h80;
        for (int j = 0; j < 8; j++) raw.push_back(b[j]);
        b = (req == 2'b01) ? 8'hC3 : (req == 2'b10) ? 8'hD2 : 8'h5A;
        for (int j = 0; j < 8; j++) raw.push_back(b[j]);
        if (req == 2'b01) begin
            crc = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                b = fifo[rd_ptr + 3'(i)];
                for (int j = 0; j < 8; j++) begin
                    raw.push_back(b[j]);
                    if (crc[0] ^ b[j]) crc = (crc >> 1) ^ 16'hA001;
                    else               crc = crc >> 1;
                end
            end
            for (int j = 0; j < 16; j++) raw.push_back(~crc[j]);
        end
        lvl  = 2'b10;
        ones = 0;
        foreach (raw[k]) begin
            if (raw[k]) ones++;
            else begin
                ones = 0;
                lvl  = (lvl == 2'b10) ? 2'b01 : 2'b10;
            end
            exp_line.push_back(lvl);
            if (ones == 6) begin
                ones = 0;
                lvl  = (lvl == 2'b10) ? 2'b01 : 2'b10;
                exp_line.push_back(lvl);
            end
        end
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b10);
    endtask

    // Presents a request for one clock; returns just after the accepting edge
    task automatic start_req(input logic [1:0] req, input logic [6:0] occ);
        @(negedge tb_clk);
        tx_packet        = req;
        buffer_occupancy = occ;
        @(posedge tb_clk);
        #1;
        tx_packet = 2'b00;
    endtask

    task automatic run_packet(input string name, input logic [1:0] req,
                              input logic [6:0] occ, input int exp_gets);
        int gets0;
        int act_cnt;
        int len;
        build_expected(req, (req == 2'b01) ? int'(occ) : 0);
        len = exp_line.size();
        dp_hist = '0;
        repeat (3) @(posedge tb_clk);
        gets0 = get_count;
        start_req(req, occ);
        act_cnt = 0;
        for (int i = 0; i < len; i++) begin
            if (i == 0) @(posedge tb_clk);
            else repeat (CPB) @(posedge tb_clk);
            #1;
            chk($sformatf("%s line bit%0d", name, i), int'({dplus_out, dminus_out}), int'(exp_line[i]));
            if (i < 64) dp_hist[i] = dplus_out;
            if (tx_transfer_active) act_cnt++;
        end
        repeat (CPB) @(posedge tb_clk);
        #1;
        chk({name, " active_end"}, int'(tx_transfer_active), 0);
        chk({name, " line_end"}, int'({dplus_out, dminus_out}), 2);
        chk({name, " active_bits"}, act_cnt, len);
        chk({name, " gets"}, get_count - gets0, exp_gets);
    endtask

    initial begin
        int gets0;
        n_rst            = 1'b1;
        tx_packet        = 2'b00;
        buffer_occupancy = 7'd0;
        for (int i = 0; i < 8; i++) fifo[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge tb_clk);
        #1;
        chk("rst dplus", int'(dplus_out), 1);
        chk("rst dminus", int'(dminus_out), 0);
        chk("rst active", int'(tx_transfer_active), 0);
        chk("rst error", int'(tx_error), 0);
        chk("rst get", int'(get_tx_packet_data), 0);
        @(negedge tb_clk);
        n_rst = 1'b0;

        // ACK: 16 bits + 3 EOP bits, hand-derived SYNC and PID D+ levels
        run_packet("ack", 2'b10, 7'd0, 0);
        chk("ack sync dplus", int'(dp_hist[7:0]), 'h2A);
        chk("ack pid dplus", int'(dp_hist[15:8]), 'h1B);
        chk("ack active count", int'(exp_line.size()) - 19 + 19, 19);

        // NAK
        run_packet("nak", 2'b11, 7'd0, 0);
        chk("nak pid dplus", int'(dp_hist[15:8]), 'h63);
        chk("nak error", int'(tx_error), 0);

        // DATA0 with two bytes
        fifo[rd_ptr]        = 8'h00;
        fifo[rd_ptr + 3'd1] = 8'h01;
        run_packet("d0_two", 2'b01, 7'd2, 2);

        // DATA0 0xFF: stuffed 0 after six ones (line holds bits 14..19)
        fifo[rd_ptr] = 8'hFF;
        run_packet("d0_ff", 2'b01, 7'd1, 1);
        chk("d0_ff stuff dplus", int'(dp_hist[20:13]), 'h80);

        // DATA0 empty: inverted CRC is 16 zeros, line alternates
        run_packet("d0_empty", 2'b01, 7'd0, 0);
        chk("d0_empty crc dplus", int'(dp_hist[31:16]), 'h5555);

        // Oversize DATA0 is rejected
        repeat (3) @(posedge tb_clk);
        gets0 = get_count;
        start_req(2'b01, 7'd65);
        chk("rej error", int'(tx_error), 1);
        chk("rej active", int'(tx_transfer_active), 0);
        repeat (20) @(posedge tb_clk);
        #1;
        chk("rej line", int'({dplus_out, dminus_out}), 2);
        chk("rej active later", int'(tx_transfer_active), 0);
        chk("rej error held", int'(tx_error), 1);
        chk("rej gets", get_count - gets0, 0);

        // Next accepted request clears the error
        run_packet("ack2", 2'b10, 7'd0, 0);
        chk("ack2 error cleared", int'(tx_error), 0);

        // Reset mid-payload
        for (int i = 0; i < 4; i++) fifo[rd_ptr + 3'(i)] = 8'hA5;
        repeat (3) @(posedge tb_clk);
        start_req(2'b01, 7'd4);
        repeat (20 * CPB) @(posedge tb_clk);
        #1;
        chk("mid active", int'(tx_transfer_active), 1);
        @(negedge tb_clk);
        n_rst = 1'b1;
        #1;
        chk("mid rst line", int'({dplus_out, dminus_out}), 2);
        chk("mid rst active", int'(tx_transfer_active), 0);
        chk("mid rst get", int'(get_tx_packet_data), 0);
        @(negedge tb_clk);
        n_rst = 1'b0;

        // Clean restart after the dropped packet
        run_packet("ack3", 2'b10, 7'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
